// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - pipelined ripple-carry adder/subtractor with valid/ready flow control
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CHUNK = WIDTH / STAGES;

    logic [STAGES-1:0][WIDTH-1:0] r_sum, r_a, r_b;
    logic [STAGES-1:0][WIDTH-1:0] src_sum, src_a, src_b, n_sum;
    logic [STAGES-1:0]            v, r_c, src_v, src_c, n_c;
    logic                         adv;
    logic                         carry;
    logic                         unused_lsbs;

    assign adv       = !v[STAGES-1] || out_ready;
    assign in_ready  = adv;
    assign out_valid = v[STAGES-1];
    assign sum       = r_sum[STAGES-1];
    assign cout      = r_c[STAGES-1];
    assign ovf       = (r_a[STAGES-1][WIDTH-1] == r_b[STAGES-1][WIDTH-1]) &&
                       (r_sum[STAGES-1][WIDTH-1] != r_a[STAGES-1][WIDTH-1]);
    assign unused_lsbs = ^{r_a[STAGES-1][WIDTH-2:0], r_b[STAGES-1][WIDTH-2:0]};

    // Stage 0 takes the raw operation with subtract folded into b and the carry-in;
    // later stages take the whole operation carried in the previous register.
    genvar k;
    for (k = 0; k < STAGES; k++) begin : g_src
        if (k == 0) begin : g_head
            assign src_v[k]   = in_valid;
            assign src_a[k]   = a;
            assign src_b[k]   = sub ? ~b : b;
            assign src_c[k]   = cin ^ sub;
            assign src_sum[k] = '0;
        end else begin : g_body
            assign src_v[k]   = v[k-1];
            assign src_a[k]   = r_a[k-1];
            assign src_b[k]   = r_b[k-1];
            assign src_c[k]   = r_c[k-1];
            assign src_sum[k] = r_sum[k-1];
        end
    end

    always_comb begin
        n_sum = src_sum;
        n_c   = '0;
        carry = 1'b0;
        for (int s = 0; s < STAGES; s++) begin
            carry = src_c[s];
            for (int i = 0; i < CHUNK; i++) begin
                n_sum[s][s*CHUNK+i] = src_a[s][s*CHUNK+i] ^ src_b[s][s*CHUNK+i] ^ carry;
                carry = (src_a[s][s*CHUNK+i] & src_b[s][s*CHUNK+i]) |
                        (carry & (src_a[s][s*CHUNK+i] ^ src_b[s][s*CHUNK+i]));
            end
            n_c[s] = carry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v     <= '0;
            r_sum <= '0;
            r_c   <= '0;
            r_a   <= '0;
            r_b   <= '0;
        end else if (adv) begin
            v     <= src_v;
            r_sum <= n_sum;
            r_c   <= n_c;
            r_a   <= src_a;
            r_b   <= src_b;
        end
    end
endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - self-checking bench for pipelined_adder across several geometries
module tb_pipelined_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        p16_in_valid, p16_in_ready, p16_cin, p16_sub, p16_out_valid, p16_out_ready, p16_cout, p16_ovf;
    logic [15:0] p16_a, p16_b, p16_sum;
    logic        p4_in_valid, p4_in_ready, p4_cin, p4_sub, p4_out_valid, p4_out_ready, p4_cout, p4_ovf;
    logic [3:0]  p4_a, p4_b, p4_sum;
    logic        p88_in_valid, p88_in_ready, p88_cin, p88_sub, p88_out_valid, p88_out_ready, p88_cout, p88_ovf;
    logic [7:0]  p88_a, p88_b, p88_sum;
    logic        p82_in_valid, p82_in_ready, p82_cin, p82_sub, p82_out_valid, p82_out_ready, p82_cout, p82_ovf;
    logic [7:0]  p82_a, p82_b, p82_sum;

    pipelined_adder #(.WIDTH(16), .STAGES(4)) u16 (
        .clk(clk), .rst(rst), .in_valid(p16_in_valid), .in_ready(p16_in_ready),
        .a(p16_a), .b(p16_b), .cin(p16_cin), .sub(p16_sub), .out_valid(p16_out_valid),
        .out_ready(p16_out_ready), .sum(p16_sum), .cout(p16_cout), .ovf(p16_ovf));
    pipelined_adder #(.WIDTH(4), .STAGES(1)) u4 (
        .clk(clk), .rst(rst), .in_valid(p4_in_valid), .in_ready(p4_in_ready),
        .a(p4_a), .b(p4_b), .cin(p4_cin), .sub(p4_sub), .out_valid(p4_out_valid),
        .out_ready(p4_out_ready), .sum(p4_sum), .cout(p4_cout), .ovf(p4_ovf));
    pipelined_adder #(.WIDTH(8), .STAGES(8)) u88 (
        .clk(clk), .rst(rst), .in_valid(p88_in_valid), .in_ready(p88_in_ready),
        .a(p88_a), .b(p88_b), .cin(p88_cin), .sub(p88_sub), .out_valid(p88_out_valid),
        .out_ready(p88_out_ready), .sum(p88_sum), .cout(p88_cout), .ovf(p88_ovf));
    pipelined_adder #(.WIDTH(8), .STAGES(2)) u82 (
        .clk(clk), .rst(rst), .in_valid(p82_in_valid), .in_ready(p82_in_ready),
        .a(p82_a), .b(p82_b), .cin(p82_cin), .sub(p82_sub), .out_valid(p82_out_valid),
        .out_ready(p82_out_ready), .sum(p82_sum), .cout(p82_cout), .ovf(p82_ovf));

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t t16[5];
    vec_t t4[4];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Integer reference: {ovf, cout, sum} for a w-bit add/subtract.
    function automatic logic [17:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
        int ia, ib, ic, res, sa, sb, sres, cy, ov;
        ia   = int'(a);
        ib   = int'(b);
        ic   = cin ? 1 : 0;
        sa   = (ia >= (1 << (w - 1))) ? ia - (1 << w) : ia;
        sb   = (ib >= (1 << (w - 1))) ? ib - (1 << w) : ib;
        res  = sub ? ia - ib - ic : ia + ib + ic;
        sres = sub ? sa - sb - ic : sa + sb + ic;
        cy   = sub ? int'(res >= 0) : int'(res >= (1 << w));
        ov   = int'((sres > (1 << (w - 1)) - 1) || (sres < -(1 << (w - 1))));
        model = {ov[0], cy[0], 16'(res & ((1 << w) - 1))};
    endfunction

    task automatic issue16(input vec_t t, input string nm, input int exp_lat);
        int lat;
        p16_a = t.a; p16_b = t.b; p16_cin = t.cin; p16_sub = t.sub; p16_in_valid = 1'b1;
        chk({nm, "_in_ready"}, 32'(p16_in_ready), 32'd1);
        step();
        p16_in_valid = 1'b0;
        lat = 0;
        while (!p16_out_valid && lat < 20) begin
            step();
            lat++;
        end
        chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({nm, "_sum"}, 32'(p16_sum), 32'(t.sum));
        chk({nm, "_cout"}, 32'(p16_cout), 32'(t.cout));
        chk({nm, "_ovf"}, 32'(p16_ovf), 32'(t.ovf));
        step();
    endtask

    task automatic issue4(input vec_t t, input string nm);
        int lat;
        p4_a = t.a[3:0]; p4_b = t.b[3:0]; p4_cin = t.cin; p4_sub = t.sub; p4_in_valid = 1'b1;
        step();
        p4_in_valid = 1'b0;
        lat = 0;
        while (!p4_out_valid && lat < 20) begin
            step();
            lat++;
        end
        chk({nm, "_latency"}, 32'(lat), 32'd0);
        chk({nm, "_cout_sum"}, 32'({p4_cout, p4_sum}), 32'({t.cout, t.sum[3:0]}));
        chk({nm, "_ovf"}, 32'(p4_ovf), 32'(t.ovf));
        step();
    endtask

    initial begin
        logic [15:0] oa[20], ob[20];
        logic        oc[20], os[20];
        logic [17:0] sb16[$], sb88[$], sb82[$];
        logic [17:0] snap, e;
        logic        stalled;
        int          sent, got, cyc, got88, got82;
        vec_t        tv;

        t16[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        t16[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        t16[2] = '{16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
        t16[3] = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        t16[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        t4[0]  = '{16'h1, 16'h0, 1'b0, 1'b0, 16'h1, 1'b0, 1'b0};
        t4[1]  = '{16'h2, 16'h4, 1'b1, 1'b0, 16'h7, 1'b0, 1'b0};
        t4[2]  = '{16'hB, 16'h6, 1'b0, 1'b0, 16'h1, 1'b1, 1'b0};
        t4[3]  = '{16'h5, 16'h3, 1'b1, 1'b0, 16'h9, 1'b0, 1'b1};

        {p16_in_valid, p16_a, p16_b, p16_cin, p16_sub} = '0; p16_out_ready = 1'b1;
        {p4_in_valid, p4_a, p4_b, p4_cin, p4_sub} = '0;     p4_out_ready  = 1'b1;
        {p88_in_valid, p88_a, p88_b, p88_cin, p88_sub} = '0; p88_out_ready = 1'b1;
        {p82_in_valid, p82_a, p82_b, p82_cin, p82_sub} = '0; p82_out_ready = 1'b1;

        rst = 1'b1;
        p16_in_valid = 1'b1;
        step();
        step();
        chk("reset_out_valid", 32'(p16_out_valid), 32'd0);
        chk("reset_in_ready", 32'(p16_in_ready), 32'd1);
        chk("reset_result", 32'({p16_ovf, p16_cout, p16_sum}), 32'd0);
        chk("reset_out_valid_w4", 32'(p4_out_valid), 32'd0);
        p16_in_valid = 1'b0;
        rst = 1'b0;
        step();
        chk("reset_in_valid_ignored", 32'(p16_out_valid), 32'd0);

        for (int i = 0; i < 5; i++) issue16(t16[i], $sformatf("w16_vec%0d", i), 3);
        for (int i = 0; i < 4; i++) issue4(t4[i], $sformatf("w4_legacy%0d", i));

        for (int i = 0; i < 20; i++) begin
            oa[i] = 16'($urandom); ob[i] = 16'($urandom);
            oc[i] = 1'($urandom); os[i] = 1'($urandom);
        end
        sent = 0; got = 0; cyc = 0; stalled = 1'b0; snap = '0;
        while (got < 20 && cyc < 500) begin
            if (stalled) begin
                chk("stall_valid", 32'(p16_out_valid), 32'd1);
                chk("stall_data", 32'({p16_ovf, p16_cout, p16_sum}), 32'(snap));
            end
            if (sent < 20) begin
                p16_a = oa[sent]; p16_b = ob[sent]; p16_cin = oc[sent]; p16_sub = os[sent];
                p16_in_valid = 1'b1;
            end else begin
                p16_in_valid = 1'b0;
            end
            p16_out_ready = 1'($urandom_range(0, 1));
            #4;
            chk("stream_in_ready", 32'(p16_in_ready), 32'(!(p16_out_valid && !p16_out_ready)));
            stalled = p16_out_valid && !p16_out_ready;
            snap = {p16_ovf, p16_cout, p16_sum};
            if (p16_in_valid && p16_in_ready) begin
                sb16.push_back(model(16, p16_a, p16_b, p16_cin, p16_sub));
                sent++;
            end
            if (p16_out_valid && p16_out_ready) begin
                if (sb16.size() == 0) chk("stream_duplicate", 32'd1, 32'd0);
                else begin
                    e = sb16.pop_front();
                    chk($sformatf("stream_result%0d", got), 32'({p16_ovf, p16_cout, p16_sum}), 32'(e));
                end
                got++;
            end
            step();
            cyc++;
        end
        chk("stream_count", 32'(got), 32'd20);
        p16_in_valid = 1'b0;
        p16_out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("stream_no_extra", 32'(p16_out_valid), 32'd0);
            step();
        end
        chk("stream_scoreboard_empty", 32'(sb16.size()), 32'd0);

        for (int i = 0; i < 3; i++) begin
            p16_a = 16'($urandom); p16_b = 16'($urandom); p16_cin = 1'b0; p16_sub = 1'b0;
            p16_in_valid = 1'b1;
            step();
        end
        p16_in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("reset_flush", 32'(p16_out_valid), 32'd0);
            step();
        end
        tv = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        issue16(tv, "post_reset", 3);

        got88 = 0; got82 = 0; cyc = 0;
        while ((got88 < 10000 || got82 < 10000) && cyc < 10100) begin
            if (cyc < 10000) begin
                p88_a = 8'($urandom); p88_b = 8'($urandom); p88_cin = 1'($urandom); p88_sub = 1'($urandom);
                p82_a = 8'($urandom); p82_b = 8'($urandom); p82_cin = 1'($urandom); p82_sub = 1'($urandom);
                p88_in_valid = 1'b1; p82_in_valid = 1'b1;
            end else begin
                p88_in_valid = 1'b0; p82_in_valid = 1'b0;
            end
            #4;
            if (p88_in_valid && p88_in_ready) sb88.push_back(model(8, {8'h0, p88_a}, {8'h0, p88_b}, p88_cin, p88_sub));
            if (p82_in_valid && p82_in_ready) sb82.push_back(model(8, {8'h0, p82_a}, {8'h0, p82_b}, p82_cin, p82_sub));
            if (p88_out_valid) begin
                e = (sb88.size() > 0) ? sb88.pop_front() : 18'h3FFFF;
                chk("sweep_w8s8", 32'({p88_ovf, p88_cout, 8'h0, p88_sum}), 32'(e));
                got88++;
            end
            if (p82_out_valid) begin
                e = (sb82.size() > 0) ? sb82.pop_front() : 18'h3FFFF;
                chk("sweep_w8s2", 32'({p82_ovf, p82_cout, 8'h0, p82_sum}), 32'(e));
                got82++;
            end
            step();
            cyc++;
        end
        chk("sweep_w8s8_count", 32'(got88), 32'd10000);
        chk("sweep_w8s2_count", 32'(got82), 32'd10000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
